// File: rtl/add_arb2.sv
// ---------------------------------------------------------------------------
// add_arb2 -- two-requester round-robin front end for one shared, pipelined
// W-bit adder.
//
// Each clock at most one requester is granted.  The granted operands are
// registered onto the adder operand bus.  A {valid, id} tag travels alongside
// every issued operation so that its sum/carry is returned, LAT+1 clocks after
// the grant edge, to the requester that issued it.  The block does no
// arithmetic of its own; the adder's carry-out is passed back unmodified.
//
// Parameters
//   W    operand / sum width
//   LAT  adder latency, in clocks, from add_a/add_b/add_ci to add_s/add_co (1..8)
//
// Ports
//   clock, reset_n          rising-edge clock, asynchronous active-low reset
//   req0/1                  requests, held high until granted
//   a0/b0/ci0, a1/b1/ci1    operands of requester 0 / 1
//   gnt0/1                  combinational grants (operands consumed that cycle)
//   add_a/add_b/add_ci      registered operand bus to the adder
//   add_s/add_co            adder result
//   rsp_valid0/1            one-clock response pulse for requester 0 / 1
//   rsp_s/rsp_co            returned sum / carry-out (hold between responses)
//
// Optional build macro ADD_ARB2_STATS_EN adds 16-bit wrapping counters:
//   gcnt0/gcnt1  grants issued to requester 0 / 1
//   ccnt         cycles in which both requesters were asking
// ---------------------------------------------------------------------------
module add_arb2 #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         req0,
  input  logic         req1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic         ci0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  input  logic         ci1,
  output logic         gnt0,
  output logic         gnt1,
  output logic [W-1:0] add_a,
  output logic [W-1:0] add_b,
  output logic         add_ci,
  input  logic [W-1:0] add_s,
  input  logic         add_co,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  output logic [W-1:0] rsp_s,
  output logic         rsp_co
`ifdef ADD_ARB2_STATS_EN
  ,
  output logic [15:0]  gcnt0,
  output logic [15:0]  gcnt1,
  output logic [15:0]  ccnt
`endif
);

  // Priority pointer: 0 -> requester 0 wins a tie, 1 -> requester 1 wins.
  logic         ptr_q, ptr_d;
  logic         gnt0_raw, gnt1_raw, any_gnt;

  logic [W-1:0] add_a_q, add_a_d;
  logic [W-1:0] add_b_q, add_b_d;
  logic         add_ci_q, add_ci_d;

  // Tag stage 0 is aligned with the operand register; stage j holds the tag
  // of the operation whose operands were presented j clocks ago, so stage
  // LAT lines up with the adder result it describes.
  logic [LAT:0] tag_vld_q, tag_vld_d;
  logic [LAT:0] tag_id_q, tag_id_d;

  logic         rsp_valid0_q, rsp_valid0_d;
  logic         rsp_valid1_q, rsp_valid1_d;
  logic [W-1:0] rsp_s_q, rsp_s_d;
  logic         rsp_co_q, rsp_co_d;

  // Arbitration.  The raw grants feed the registers (which are held in reset
  // anyway); the outputs are additionally masked while reset is asserted.
  always_comb begin
    gnt0_raw = req0 & (~req1 | ~ptr_q);
    gnt1_raw = req1 & (~req0 | ptr_q);
    any_gnt  = gnt0_raw | gnt1_raw;
  end

  assign gnt0 = gnt0_raw & reset_n;
  assign gnt1 = gnt1_raw & reset_n;

  // Issue: pointer moves to the requester that was not served; the operand
  // bus only changes on a grant so the adder inputs never toggle when idle.
  always_comb begin
    ptr_d    = ptr_q;
    add_a_d  = add_a_q;
    add_b_d  = add_b_q;
    add_ci_d = add_ci_q;
    if (gnt0_raw) begin
      ptr_d    = 1'b1;
      add_a_d  = a0;
      add_b_d  = b0;
      add_ci_d = ci0;
    end else if (gnt1_raw) begin
      ptr_d    = 1'b0;
      add_a_d  = a1;
      add_b_d  = b1;
      add_ci_d = ci1;
    end
  end

  // Tag shift and response routing.
  always_comb begin
    tag_vld_d    = {tag_vld_q[LAT-1:0], any_gnt};
    tag_id_d     = {tag_id_q[LAT-1:0], gnt1_raw};
    rsp_valid0_d = tag_vld_q[LAT] & ~tag_id_q[LAT];
    rsp_valid1_d = tag_vld_q[LAT] &  tag_id_q[LAT];
    rsp_s_d      = rsp_s_q;
    rsp_co_d     = rsp_co_q;
    if (tag_vld_q[LAT]) begin
      rsp_s_d  = add_s;
      rsp_co_d = add_co;
    end
  end

  // ---- issue stage: pointer, operand bus, tag valid bits ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q     <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      add_ci_q  <= 1'b0;
      tag_vld_q <= '0;
    end else begin
      ptr_q     <= ptr_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      add_ci_q  <= add_ci_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // Tag ids are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clock) begin
    tag_id_q <= tag_id_d;
  end

  // ---- response stage ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_s_q      <= '0;
      rsp_co_q     <= 1'b0;
    end else begin
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_s_q      <= rsp_s_d;
      rsp_co_q     <= rsp_co_d;
    end
  end

  assign add_a      = add_a_q;
  assign add_b      = add_b_q;
  assign add_ci     = add_ci_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_s      = rsp_s_q;
  assign rsp_co     = rsp_co_q;

`ifdef ADD_ARB2_STATS_EN
  logic [15:0] gcnt0_q, gcnt0_d;
  logic [15:0] gcnt1_q, gcnt1_d;
  logic [15:0] ccnt_q, ccnt_d;

  // Contention always produces a grant, so every increment lands on an edge
  // where the pointer also moves.  Counters wrap naturally at 16 bits.
  always_comb begin
    gcnt0_d = gcnt0_q;
    gcnt1_d = gcnt1_q;
    ccnt_d  = ccnt_q;
    if (gnt0_raw)     gcnt0_d = gcnt0_q + 16'd1;
    if (gnt1_raw)     gcnt1_d = gcnt1_q + 16'd1;
    if (req0 && req1) ccnt_d  = ccnt_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gcnt0_q <= '0;
      gcnt1_q <= '0;
      ccnt_q  <= '0;
    end else begin
      gcnt0_q <= gcnt0_d;
      gcnt1_q <= gcnt1_d;
      ccnt_q  <= ccnt_d;
    end
  end

  assign gcnt0 = gcnt0_q;
  assign gcnt1 = gcnt1_q;
  assign ccnt  = ccnt_q;
`endif

endmodule

// File: tb/tb_add_arb2.sv
// ---------------------------------------------------------------------------
// tb_add_arb2 -- self-checking bench for add_arb2.
// A behavioural adder with LAT register stages stands in for the shared adder.
// The monitor keeps a fairness model (whoever was not served last wins a tie),
// pushes the expected {id, sum, carry, due cycle} on every modelled grant and
// pops/compares when the response is due.
// ---------------------------------------------------------------------------
module tb_add_arb2;
  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         req0, req1;
  logic [W-1:0] a0, b0, a1, b1;
  logic         ci0, ci1;
  logic         gnt0, gnt1;
  logic [W-1:0] add_a, add_b;
  logic         add_ci;
  logic [W-1:0] add_s;
  logic         add_co;
  logic         rsp_valid0, rsp_valid1;
  logic [W-1:0] rsp_s;
  logic         rsp_co;
`ifdef ADD_ARB2_STATS_EN
  logic [15:0]  gcnt0, gcnt1, ccnt;
`endif

  add_arb2 #(.W(W), .LAT(LAT)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .ci0(ci0),
    .a1(a1), .b1(b1), .ci1(ci1),
    .gnt0(gnt0), .gnt1(gnt1),
    .add_a(add_a), .add_b(add_b), .add_ci(add_ci),
    .add_s(add_s), .add_co(add_co),
    .rsp_valid0(rsp_valid0), .rsp_valid1(rsp_valid1),
    .rsp_s(rsp_s), .rsp_co(rsp_co)
`ifdef ADD_ARB2_STATS_EN
    , .gcnt0(gcnt0), .gcnt1(gcnt1), .ccnt(ccnt)
`endif
  );

  always #5 clock = ~clock;

  // Behavioural pipelined adder: result appears LAT clocks after the operands.
  logic [W:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= 33'(add_a) + 33'(add_b) + 33'(add_ci);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign add_s  = pipe[LAT-1][W-1:0];
  assign add_co = pipe[LAT-1][W];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    bit           id;
    logic [W-1:0] s;
    bit           co;
    int           due;
  } exp_t;
  exp_t q[$];

  // ---------------- reference model + monitor ----------------
  bit           prio;           // requester that wins a tie
  logic [W-1:0] exp_a, exp_b, last_s;
  logic         exp_ci, last_co;
  int           w0, w1;
  logic [15:0]  exp_g0, exp_g1, exp_cc;

  always @(negedge clock) begin : monitor
    exp_t         e;
    bit           eg0, eg1;
    logic [W:0]   sum;
    if (!reset_n) begin
      chk("rst_gnt",   64'({gnt1, gnt0}), 64'd0);
      chk("rst_add",   64'({add_ci, add_a, add_b} != '0), 64'd0);
      chk("rst_rsp",   64'({rsp_valid1, rsp_valid0, rsp_co, rsp_s} != '0), 64'd0);
      q.delete();
      prio = 1'b0; exp_a = '0; exp_b = '0; exp_ci = 1'b0;
      last_s = '0; last_co = 1'b0; w0 = 0; w1 = 0;
      exp_g0 = '0; exp_g1 = '0; exp_cc = '0;
    end else begin
      eg0 = req0 && (!req1 || prio == 1'b0);
      eg1 = req1 && (!req0 || prio == 1'b1);
      chk("grant",      64'({gnt1, gnt0}), 64'({eg1, eg0}));
      chk("gnt_excl",   64'(gnt0 & gnt1), 64'd0);
      chk("add_bus",    64'({add_ci, add_a} ^ {exp_ci, exp_a}) | 64'(add_b ^ exp_b), 64'd0);
`ifdef ADD_ARB2_STATS_EN
      chk("gcnt0", 64'(gcnt0), 64'(exp_g0));
      chk("gcnt1", 64'(gcnt1), 64'(exp_g1));
      chk("ccnt",  64'(ccnt),  64'(exp_cc));
`endif
      if (q.size() != 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", 64'({rsp_valid1, rsp_valid0}), e.id ? 64'd2 : 64'd1);
        chk("rsp_s",     64'(rsp_s), 64'(e.s));
        chk("rsp_co",    64'(rsp_co), 64'(e.co));
        last_s = e.s; last_co = e.co;
      end else begin
        chk("rsp_idle",  64'({rsp_valid1, rsp_valid0}), 64'd0);
        chk("rsp_hold",  64'({rsp_co, rsp_s}), 64'({last_co, last_s}));
      end
      // A held request must never wait more than one cycle.
      if (req0) begin
        w0 = gnt0 ? 0 : w0 + 1;
        chk("wait0", 64'(w0 > 1), 64'd0);
      end else w0 = 0;
      if (req1) begin
        w1 = gnt1 ? 0 : w1 + 1;
        chk("wait1", 64'(w1 > 1), 64'd0);
      end else w1 = 0;
      if (req0 && req1) exp_cc = exp_cc + 16'd1;
      if (eg0) begin
        sum = 33'(a0) + 33'(b0) + 33'(ci0);
        q.push_back('{id: 1'b0, s: sum[W-1:0], co: sum[W], due: cyc + LAT + 2});
        exp_a = a0; exp_b = b0; exp_ci = ci0; prio = 1'b1;
        exp_g0 = exp_g0 + 16'd1;
      end else if (eg1) begin
        sum = 33'(a1) + 33'(b1) + 33'(ci1);
        q.push_back('{id: 1'b1, s: sum[W-1:0], co: sum[W], due: cyc + LAT + 2});
        exp_a = a1; exp_b = b1; exp_ci = ci1; prio = 1'b0;
        exp_g1 = exp_g1 + 16'd1;
      end
    end
  end

  // ---------------- stimulus ----------------
  logic g0_s, g1_s;

  task automatic tick();
    @(negedge clock);
    g0_s = gnt0;
    g1_s = gnt1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; ci0 = 1'b0;
    a1 = '0; b1 = '0; ci1 = 1'b0;
    g0_s = 1'b0; g1_s = 1'b0;
    repeat (3) tick();
    reset_n = 1'b1;

    // Lone requester 0: all-ones + 0 + 1 wraps to zero with carry out.
    a0 = 32'hFFFF_FFFF; b0 = 32'h0; ci0 = 1'b1; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    repeat (LAT + 3) tick();

    // Lone requester 1: no carry.
    a1 = 32'h0000_FFFF; b1 = 32'hFFFF_0000; ci1 = 1'b0; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    repeat (LAT + 3) tick();

    // Fresh reset so the contention run starts from cleared counters.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;

    // Contention for four clocks: grants alternate 0,1,0,1.
    a0 = 32'h135F_A562; b0 = 32'h3561_4642; ci0 = 1'b0;
    a1 = 32'h1; b1 = 32'h1; ci1 = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    repeat (4) tick();
    req0 = 1'b0; req1 = 1'b0;
    repeat (LAT + 3) tick();

    // Grant requester 1 (moves pointer to 0), then requester 0, then reset
    // before requester 0's result is due.
    a1 = 32'h2222_0000; b1 = 32'h0000_3333; ci1 = 1'b0; req1 = 1'b1;
    tick();
    req1 = 1'b0;
    a0 = 32'hDEAD_BEEF; b0 = 32'h1234_5678; ci0 = 1'b1; req0 = 1'b1;
    tick();
    req0 = 1'b0;
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (LAT + 3) tick();

    // Pointer must be back on requester 0 after reset.
    a0 = 32'h0000_0010; b0 = 32'h0000_0020; ci0 = 1'b0;
    a1 = 32'h8000_0000; b1 = 32'h8000_0000; ci1 = 1'b0;
    req0 = 1'b1; req1 = 1'b1;
    repeat (2) tick();
    req0 = 1'b0; req1 = 1'b0;

    // Idle after traffic: bus holds, responses drain then stay quiet.
    repeat (LAT + 6) tick();

    // Randomised traffic honouring the hold-until-granted protocol.
    for (int i = 0; i < 1000; i++) begin
      if (!req0 || g0_s) begin
        req0 = ($urandom_range(0, 3) != 0);
        a0   = $urandom;
        b0   = $urandom;
        ci0  = 1'($urandom_range(0, 1));
      end
      if (!req1 || g1_s) begin
        req1 = ($urandom_range(0, 3) != 0);
        a1   = $urandom;
        b1   = $urandom;
        ci1  = 1'($urandom_range(0, 1));
      end
      tick();
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (LAT + 4) tick();
    chk("drain", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
